// File: rtl/seg7_scan_driver_if.sv
// Pin-side bundle of the seven-segment scan driver: capture inputs from the datapath, anode/segment drives to the board.
// The master modport is the datapath/bench side and the slave modport is the driver.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] hex_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    lz_suppress;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;

    modport master (
        output load, hex_in, dp_in, digit_en, lz_suppress,
        input  an, seg, dp
    );

    modport slave (
        input  load, hex_in, dp_in, digit_en, lz_suppress,
        output an, seg, dp
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-seg driver: shadowed hex/dp/enable, per-slot blanking, leading-zero suppression.
// Outputs registered, 1 cycle behind scan/shadow state; no backpressure, load is accepted on every cycle.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    seg7_scan_driver_if.slave bus
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] sh_hex_q;
    logic [NUM_DIGITS-1:0]   sh_dp_q;
    logic [NUM_DIGITS-1:0]   sh_en_q;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;

    logic [3:0]              nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   supp;
    logic                    nz_above;
    logic                    in_blank;
    logic                    lit;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Walk from the most significant digit down; a digit stays suppressible
    // only while no enabled digit above it has shown a non-zero nibble.
    always_comb begin
        nz_above = 1'b0;
        supp     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib[i]   = sh_hex_q[4*i +: 4];
            supp[i]  = bus.lz_suppress && (i != 0) && (nib[i] == 4'd0) && !nz_above;
            nz_above = nz_above | (sh_en_q[i] && (nib[i] != 4'd0));
        end
    end

    generate
        if (BLANK_CYCLES > 0) begin : g_blank
            assign in_blank = (cnt_q < CNT_W'(BLANK_CYCLES));
        end else begin : g_no_blank
            assign in_blank = 1'b0;
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        lit   = !in_blank && sh_en_q[idx_q] && !supp[idx_q];
        an_d  = '1;
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        if (lit) begin
            an_d[idx_q] = 1'b0;
            seg_d       = decode(nib[idx_q]);
            dp_d        = ~sh_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_hex_q <= '0;
            sh_dp_q  <= '0;
            sh_en_q  <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            an_q     <= '1;
            seg_q    <= 7'b1111111;
            dp_q     <= 1'b1;
        end else begin
            if (bus.load) begin
                sh_hex_q <= bus.hex_in;
                sh_dp_q  <= bus.dp_in;
                sh_en_q  <= bus.digit_en;
            end
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver at 4 digits, 4-cycle slots, 1 blank cycle.
module tb_seg7_scan_driver;

    localparam int ND = 4;

    localparam logic [6:0] S_OFF = 7'b1111111;
    localparam logic [6:0] S0    = 7'b0000001;
    localparam logic [6:0] S1    = 7'b1001111;
    localparam logic [6:0] S3    = 7'b0000110;
    localparam logic [6:0] S5    = 7'b0100100;
    localparam logic [6:0] S7    = 7'b0001111;
    localparam logic [6:0] S8    = 7'b0000000;
    localparam logic [6:0] SA    = 7'b0001000;
    localparam logic [6:0] SF    = 7'b0111000;

    typedef struct {
        logic        ld;
        logic [15:0] hex;
        logic [3:0]  dpi;
        logic [3:0]  en;
        logic        lz;
        int          n;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    vec_t vecs [29];

    seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (4),
        .BLANK_CYCLES(1)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] ean, input logic [6:0] eseg, input logic edp);
        total++;
        if ({bus.an, bus.seg, bus.dp} !== {ean, eseg, edp}) begin
            bad++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     name, bus.an, bus.seg, bus.dp, ean, eseg, edp);
        end
    endtask

    task automatic wait_an(input string name, input logic [3:0] target, input int bound);
        int k;
        for (k = 0; k < bound; k++) begin
            tick();
            if (bus.an === target) break;
        end
        total++;
        if (k == bound) begin
            bad++;
            $display("FAIL %s: an never reached %b within %0d cycles (last an=%b)", name, target, bound, bus.an);
        end
    endtask

    task automatic drive(input logic ld, input logic [15:0] hex, input logic [3:0] dpi,
                         input logic [3:0] en, input logic lz);
        bus.load        = ld;
        bus.hex_in      = hex;
        bus.dp_in       = dpi;
        bus.digit_en    = en;
        bus.lz_suppress = lz;
    endtask

    initial begin
        int lit_cnt;
        total = 0;
        bad   = 0;

        //          ld   hex       dpi      en     lz   n  an       seg    dp
        vecs[0]  = '{1'b1, 16'h1A3F, 4'b0100, 4'hF, 1'b0, 1, 4'b1111, S_OFF, 1'b1};
        vecs[1]  = '{1'b0, 16'h1A3F, 4'b0100, 4'hF, 1'b0, 1, 4'b1110, SF,    1'b1};
        vecs[2]  = '{1'b0, 16'h1A3F, 4'b0100, 4'hF, 1'b0, 2, 4'b1110, SF,    1'b1};
        vecs[3]  = '{1'b0, 16'h1A3F, 4'b0100, 4'hF, 1'b0, 1, 4'b1111, S_OFF, 1'b1};
        vecs[4]  = '{1'b0, 16'h1A3F, 4'b0100, 4'hF, 1'b0, 1, 4'b1101, S3,    1'b1};
        vecs[5]  = '{1'b0, 16'h1A3F, 4'b0100, 4'hF, 1'b0, 3, 4'b1111, S_OFF, 1'b1};
        vecs[6]  = '{1'b0, 16'h1A3F, 4'b0100, 4'hF, 1'b0, 1, 4'b1011, SA,    1'b0};
        vecs[7]  = '{1'b0, 16'h1A3F, 4'b0100, 4'hF, 1'b0, 4, 4'b0111, S1,    1'b1};
        vecs[8]  = '{1'b0, 16'h1A3F, 4'b0100, 4'hF, 1'b0, 3, 4'b1111, S_OFF, 1'b1};
        vecs[9]  = '{1'b0, 16'h1A3F, 4'b0100, 4'hF, 1'b0, 1, 4'b1110, SF,    1'b1};
        vecs[10] = '{1'b1, 16'h0070, 4'b0000, 4'hF, 1'b1, 1, 4'b1110, SF,    1'b1};
        vecs[11] = '{1'b0, 16'h0070, 4'b0000, 4'hF, 1'b1, 1, 4'b1110, S0,    1'b1};
        vecs[12] = '{1'b0, 16'h0070, 4'b0000, 4'hF, 1'b1, 3, 4'b1101, S7,    1'b1};
        vecs[13] = '{1'b0, 16'h0070, 4'b0000, 4'hF, 1'b1, 4, 4'b1111, S_OFF, 1'b1};
        vecs[14] = '{1'b0, 16'h0070, 4'b0000, 4'hF, 1'b1, 4, 4'b1111, S_OFF, 1'b1};
        vecs[15] = '{1'b0, 16'h0070, 4'b0000, 4'hF, 1'b0, 4, 4'b1110, S0,    1'b1};
        vecs[16] = '{1'b0, 16'h0070, 4'b0000, 4'hF, 1'b0, 4, 4'b1101, S7,    1'b1};
        vecs[17] = '{1'b0, 16'h0070, 4'b0000, 4'hF, 1'b0, 4, 4'b1011, S0,    1'b1};
        vecs[18] = '{1'b0, 16'h0070, 4'b0000, 4'hF, 1'b0, 4, 4'b0111, S0,    1'b1};
        vecs[19] = '{1'b1, 16'h8888, 4'b0000, 4'hA, 1'b0, 4, 4'b1111, S_OFF, 1'b1};
        vecs[20] = '{1'b0, 16'h8888, 4'b0000, 4'hA, 1'b0, 4, 4'b1101, S8,    1'b1};
        vecs[21] = '{1'b0, 16'h8888, 4'b0000, 4'hA, 1'b0, 4, 4'b1111, S_OFF, 1'b1};
        vecs[22] = '{1'b0, 16'h8888, 4'b0000, 4'hA, 1'b0, 4, 4'b0111, S8,    1'b1};
        vecs[23] = '{1'b1, 16'h0000, 4'b1111, 4'hF, 1'b1, 4, 4'b1110, S0,    1'b0};
        vecs[24] = '{1'b0, 16'h0000, 4'b1111, 4'hF, 1'b1, 4, 4'b1111, S_OFF, 1'b1};
        vecs[25] = '{1'b1, 16'h5010, 4'b0000, 4'h7, 1'b1, 4, 4'b1111, S_OFF, 1'b1};
        vecs[26] = '{1'b0, 16'h5010, 4'b0000, 4'h7, 1'b1, 4, 4'b1111, S_OFF, 1'b1};
        vecs[27] = '{1'b0, 16'h5010, 4'b0000, 4'h7, 1'b1, 4, 4'b1110, S0,    1'b1};
        vecs[28] = '{1'b0, 16'h5010, 4'b0000, 4'h7, 1'b1, 4, 4'b1101, S1,    1'b1};

        reset_n = 1'b0;
        drive(1'b0, 16'h0000, 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("reset_hold%0d", i), 4'b1111, S_OFF, 1'b1);
        end
        reset_n = 1'b1;

        for (int i = 0; i < 29; i++) begin
            drive(vecs[i].ld, vecs[i].hex, vecs[i].dpi, vecs[i].en, vecs[i].lz);
            tick();
            bus.load = 1'b0;
            for (int k = 1; k < vecs[i].n; k++) tick();
            chk($sformatf("row%0d", i), vecs[i].an, vecs[i].seg, vecs[i].dp);
        end

        // Mid-slot reload of digit 1 while it is lit.
        wait_an("leave_slot1", 4'b1111, 8);
        wait_an("enter_slot1", 4'b1101, 40);
        drive(1'b1, 16'h5050, 4'b0000, 4'h7, 1'b1);
        tick();
        bus.load = 1'b0;
        chk("midslot_old", 4'b1101, S1, 1'b1);
        tick();
        chk("midslot_new", 4'b1101, S5, 1'b1);

        // Asynchronous reset in the middle of slot 2.
        bus.lz_suppress = 1'b0;
        wait_an("enter_slot2", 4'b1011, 40);
        chk("slot2_lit", 4'b1011, S0, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_dark", 4'b1111, S_OFF, 1'b1);
        tick();
        tick();
        chk("reset_held", 4'b1111, S_OFF, 1'b1);
        reset_n = 1'b1;

        lit_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if ({bus.an, bus.seg, bus.dp} !== {4'b1111, S_OFF, 1'b1}) lit_cnt++;
        end
        total++;
        if (lit_cnt != 0) begin
            bad++;
            $display("FAIL shadow_cleared: got %0d lit cycles after reset, want 0", lit_cnt);
        end

        // Eight cycles after release the scan sits at slot 2, count 0.
        drive(1'b1, 16'h1A3F, 4'b0100, 4'hF, 1'b0);
        tick();
        bus.load = 1'b0;
        chk("restart_blank", 4'b1111, S_OFF, 1'b1);
        tick();
        chk("restart_idx2", 4'b1011, SA, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
